// File: rtl/branch_predictor_if.sv
// +--------------------------------------------------------------------+
// | branch_predictor_if                                                |
// | Fetch lookup, execute training, invalidate and counter signals.    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

interface branch_predictor_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  en_f;
    logic [DATA_WIDTH-1:0] PC_f;
    logic                  predict_taken;
    logic [DATA_WIDTH-1:0] branch_target;
    logic                  upd_valid;
    logic [DATA_WIDTH-1:0] upd_PC;
    logic                  upd_taken;
    logic [DATA_WIDTH-1:0] upd_target;
    logic                  upd_mispredict;
    logic                  inv_req;
    logic                  inv_busy;
    logic [31:0]           lookup_cnt;
    logic [31:0]           mispredict_cnt;

    modport master (
        output en_f, PC_f, upd_valid, upd_PC, upd_taken, upd_target,
               upd_mispredict, inv_req,
        input  predict_taken, branch_target, inv_busy, lookup_cnt,
               mispredict_cnt
    );

    modport slave (
        input  en_f, PC_f, upd_valid, upd_PC, upd_taken, upd_target,
               upd_mispredict, inv_req,
        output predict_taken, branch_target, inv_busy, lookup_cnt,
               mispredict_cnt
    );
endinterface

`default_nettype wire

// File: rtl/branch_predictor.sv
// +--------------------------------------------------------------------+
// | branch_predictor                                                   |
// | Direct-mapped BTB with 2-bit counters and a sequential invalidate. |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module branch_predictor #(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 16
) (
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_INV  = 1'b1
    } state_t;

    logic                  r_valid  [ENTRIES];
    logic [1:0]            r_ctr    [ENTRIES];
    logic [TAG_W-1:0]      r_tag    [ENTRIES];
    logic [DATA_WIDTH-1:0] r_target [ENTRIES];

    state_t                r_state;
    logic [IDX_W-1:0]      r_ptr;
    logic                  r_inv_busy;
    logic [31:0]           r_lookup_cnt;
    logic [31:0]           r_mispredict_cnt;

    logic [IDX_W-1:0]      w_f_idx;
    logic [TAG_W-1:0]      w_f_tag;
    logic                  w_f_hit;
    logic [IDX_W-1:0]      w_u_idx;
    logic [TAG_W-1:0]      w_u_tag;
    logic                  w_u_hit;
    logic [1:0]            w_ctr_next;
    logic                  w_unused;

    assign w_f_idx = bus.PC_f[IDX_W+1:2];
    assign w_f_tag = bus.PC_f[DATA_WIDTH-1:IDX_W+2];
    assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);

    assign w_u_idx = bus.upd_PC[IDX_W+1:2];
    assign w_u_tag = bus.upd_PC[DATA_WIDTH-1:IDX_W+2];
    assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

    // Instruction-aligned PCs never use the two low bits.
    assign w_unused = ^{bus.PC_f[1:0], bus.upd_PC[1:0]};

    always_comb begin
        w_ctr_next = r_ctr[w_u_idx];
        if (bus.upd_taken) begin
            if (r_ctr[w_u_idx] != 2'b11) w_ctr_next = r_ctr[w_u_idx] + 2'b01;
        end else begin
            if (r_ctr[w_u_idx] != 2'b00) w_ctr_next = r_ctr[w_u_idx] - 2'b01;
        end
    end

    assign bus.predict_taken  = w_f_hit & r_ctr[w_f_idx][1] & ~r_inv_busy;
    assign bus.branch_target  = w_f_hit ? r_target[w_f_idx] : '0;
    assign bus.inv_busy       = r_inv_busy;
    assign bus.lookup_cnt     = r_lookup_cnt;
    assign bus.mispredict_cnt = r_mispredict_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_ctr[i]    <= 2'b01;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
            r_state          <= ST_IDLE;
            r_ptr            <= '0;
            r_inv_busy       <= 1'b0;
            r_lookup_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (bus.en_f && !r_inv_busy) r_lookup_cnt <= r_lookup_cnt + 32'd1;
            // Counted even when the training update itself is dropped.
            if (bus.upd_valid && bus.upd_mispredict)
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;

            case (r_state)
                ST_IDLE: begin
                    if (bus.inv_req) begin
                        r_state    <= ST_INV;
                        r_ptr      <= '0;
                        r_inv_busy <= 1'b1;
                    end else if (bus.upd_valid) begin
                        if (w_u_hit) begin
                            r_ctr[w_u_idx] <= w_ctr_next;
                            if (bus.upd_taken) r_target[w_u_idx] <= bus.upd_target;
                        end else if (bus.upd_taken) begin
                            r_valid[w_u_idx]  <= 1'b1;
                            r_tag[w_u_idx]    <= w_u_tag;
                            r_target[w_u_idx] <= bus.upd_target;
                            r_ctr[w_u_idx]    <= 2'b10;
                        end
                    end
                end
                ST_INV: begin
                    r_valid[r_ptr] <= 1'b0;
                    r_ctr[r_ptr]   <= 2'b01;
                    r_ptr          <= r_ptr + IDX_W'(1);
                    if (r_ptr == IDX_W'(ENTRIES - 1)) begin
                        r_state    <= ST_IDLE;
                        r_inv_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_inv_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the fetch stage of the pipelined core. It holds a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry. Each cycle it returns a same-cycle taken/target prediction for the fetch PC, which drives the `predict_taken` / `branch_target` inputs of the PC-select logic. The execute stage trains it with resolved branch outcomes, and a multi-cycle invalidate sequencer flushes it on `fence.i`.

## Interface
- `DATA_WIDTH`, 32, PC and target width.
- `ENTRIES`, 16, number of BTB entries; must be a power of two, at least 2. `IDX_W = log2(ENTRIES)`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `en_f`  in  1  fetch enable; low means fetch is stalled.
- `PC_f`  in  DATA_WIDTH  current fetch PC.
- `predict_taken`  out  1  prediction that `PC_f` is a taken branch.
- `branch_target`  out  DATA_WIDTH  predicted target for `PC_f`.
- `upd_valid`  in  1  a branch or jump resolved in execute this cycle.
- `upd_PC`  in  DATA_WIDTH  PC of the resolved branch.
- `upd_taken`  in  1  actual outcome of the resolved branch.
- `upd_target`  in  DATA_WIDTH  actual target of the resolved branch.
- `upd_mispredict`  in  1  execute-stage flag: the prediction for this branch was wrong.
- `inv_req`  in  1  request to invalidate the whole BTB.
- `inv_busy`  out  1  invalidate sequence in progress.
- `lookup_cnt`  out  32  performance counter: number of predictions issued.
- `mispredict_cnt`  out  32  performance counter: number of mispredicts.

## Operation
- **Addressing:** index = `PC[IDX_W+1:2]`; tag = `PC[DATA_WIDTH-1:IDX_W+2]`.
- **Entry contents:** `valid`, `tag`, `target`, 2-bit counter. Counter encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- **Lookup:** hit = `valid & tag match`.
  - `predict_taken` = hit & `ctr[1]` & `!inv_busy`.
  - `branch_target` = entry target on a hit, else 0.
- **Update on hit** (`upd_valid` and `upd_PC` hits):
  - counter increments if `upd_taken`, else decrements; it saturates at 11 and 00.
  - if `upd_taken`, the target is overwritten with `upd_target`.
- **Update on miss:**
  - if `upd_taken`, allocate the entry (overwriting any other tag at that index): `valid=1`, new tag, `target=upd_target`, counter=10.
  - if not taken, no change.
- **Invalidate FSM** has two states, IDLE and INV:
  - IDLE → INV when `inv_req`; index pointer set to 0.
  - In INV, the entry at the pointer gets `valid=0` and counter=01, then the pointer increments.
  - INV → IDLE after clearing entry `ENTRIES-1`.
  - `inv_busy` = (state == INV).
- **Invalidate conflicts:**
  - `inv_req` while in INV is ignored (no restart).
  - `upd_valid` while in INV, or in the cycle `inv_req` is accepted, is dropped; invalidate wins.
- **Counters:**
  - `lookup_cnt` increments on each cycle with `en_f & !inv_busy`.
  - `mispredict_cnt` increments on each cycle with `upd_valid & upd_mispredict`, including cycles where the update itself is dropped.
  - both wrap from 0xFFFFFFFF to 0.
- **Reset (`rst` low):**
  - every entry gets `valid=0`, counter=01, tag=0, target=0.
  - FSM goes to IDLE and the pointer to 0.
  - both counters go to 0.
  - outputs: `predict_taken=0`, `branch_target=0`, `inv_busy=0`.
  - assertion mid-invalidate aborts the sequence immediately.

## Timing
- Lookup is combinational from `PC_f` and stored state; the prediction is valid in the same cycle as `PC_f`.
- An update sampled at edge N is visible to lookups from cycle N+1. A same-cycle lookup of the entry being updated returns the pre-update value.
- `inv_req` sampled at edge N: `inv_busy` is high for exactly `ENTRIES` cycles, from N+1 through N+`ENTRIES`. Entry k is cleared at edge N+1+k.
- The first lookup after the sequence sees all entries invalid.
- Counters update on the same edge as their qualifying condition; the new value appears on the outputs the next cycle.
- `en_f=0` does not block updates or invalidation; it only suppresses `lookup_cnt`.

## Test plan
All scenarios use `ENTRIES=16`.
- **Reset:** pulse `rst` low mid-run, then drive `PC_f=0x100` → `predict_taken=0`, `branch_target=0`, `inv_busy=0`, `lookup_cnt=0`, `mispredict_cnt=0`.
- **Allocate / alias:** update `upd_PC=0x100`, taken, target `0x80`.
  - next cycle, `PC_f=0x100` → `predict_taken=1`, `branch_target=0x80`.
  - `PC_f=0x500` (same index 0, different tag) → `predict_taken=0`, `branch_target=0`.
  - a taken update at `0x500` then evicts `0x100`, which subsequently misses.
- **Hysteresis at `0x100`:**
  - after allocation, two taken updates → counter 11.
  - one not-taken → 10, `predict_taken=1`.
  - second not-taken → 01, `predict_taken=0`.
  - two more not-taken → counter stays at 00.
- **Same-cycle update/lookup:** entry at 01, apply a taken update with `PC_f=0x100` in the same cycle → `predict_taken=0` that cycle, 1 the next.
- **Invalidate:** fill entries at `0x100` and `0x104`, pulse `inv_req`.
  - `inv_busy` is high for exactly 16 cycles with `predict_taken=0` throughout.
  - a taken update issued while busy, and a second `inv_req` while busy, are both ignored.
  - afterwards both PCs miss.
- **Counters:** run 10 cycles with `en_f=1` and 4 with `en_f=0`; assert `upd_mispredict` on 3 of them, one while busy.
  - expect `lookup_cnt=10`, `mispredict_cnt=3`.
  - preload near wrap to check 0xFFFFFFFF → 0.
